mtf_encoder: RTL and testbench

- Move-to-front encoder directly downstream of the BWT stage.
- Consumes the BWT output byte stream one character per valid cycle, in blocks of STRING_LEN characters.
- Emits one 8-bit MTF index per input character through a small output FIFO with a valid/ready handshake.
- Feeds the later entropy/run-length stages.
- The 256-entry MTF table is reinitialised to identity at every block boundary, so each BWT block encodes independently.

---
 rtl/mtf_encoder.sv | 110 +++++++++++
 tb/tb_mtf_encoder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mtf_encoder.sv
// Move-to-front encoder: one 8-bit index per accepted character, table reset to
// identity at every block boundary, results buffered in a small output FIFO.
module mtf_encoder #(
  parameter int STRING_LEN = 128,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_char,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_idx,
  output logic       out_last,
  output logic       overflow
);

  localparam int          PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [15:0] LAST_POS = 16'(STRING_LEN - 1);

  logic [7:0]    r_table [256];
  logic [7:0]    w_table_nxt [256];
  logic [7:0]    w_idx;
  logic          w_last;
  logic          w_accept;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [15:0]   r_cnt;
  logic [7:0]    r_mem_idx [FIFO_DEPTH];
  logic          r_mem_last [FIFO_DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW:0]   r_count;
  logic [7:0]    r_hold_idx;
  logic          r_hold_last;
  logic          r_overflow;

  assign w_full    = (r_count == (PW+1)'(FIFO_DEPTH));
  assign w_empty   = (r_count == '0);
  assign in_ready  = !w_full;
  assign out_valid = !w_empty;
  assign w_accept  = in_valid & !w_full;
  assign w_pop     = !w_empty & out_ready;
  assign w_last    = (r_cnt == LAST_POS);
  assign overflow  = r_overflow;

  // An empty FIFO shows the most recently popped entry so out_idx never goes stale/X.
  assign out_idx   = w_empty ? r_hold_idx  : r_mem_idx[r_rptr];
  assign out_last  = w_empty ? r_hold_last : r_mem_last[r_rptr];

  // Parallel search: every character occurs exactly once in the table.
  always_comb begin
    w_idx = '0;
    for (int p = 0; p < 256; p++) begin
      if (r_table[p] == in_char) w_idx = 8'(p);
    end
  end

  // Next table: identity on reset or block end, otherwise move the hit to the front.
  always_comb begin
    w_table_nxt[0] = (rst || w_last) ? 8'd0 : in_char;
    for (int k = 1; k < 256; k++) begin
      if (rst || w_last)          w_table_nxt[k] = 8'(k);
      else if (k <= int'(w_idx))  w_table_nxt[k] = r_table[k-1];
      else                        w_table_nxt[k] = r_table[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || w_accept) r_table <= w_table_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_hold_idx  <= '0;
      r_hold_last <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt  <= w_last ? 16'd0 : r_cnt + 16'd1;
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr      <= r_rptr + 1'b1;
        r_hold_idx  <= r_mem_idx[r_rptr];
        r_hold_last <= r_mem_last[r_rptr];
      end
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (in_valid && w_full) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem_idx[r_wptr]  <= w_idx;
      r_mem_last[r_wptr] <= w_last;
    end
  end

endmodule

// File: tb/tb_mtf_encoder.sv
// Directed bench for mtf_encoder: instance A uses default parameters,
// instance B uses STRING_LEN=4 / FIFO_DEPTH=4; both share the input stimulus.
module tb_mtf_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_char;
  logic       out_ready;

  logic       a_in_ready, a_out_valid, a_out_last, a_overflow;
  logic [7:0] a_out_idx;
  logic       b_in_ready, b_out_valid, b_out_last, b_overflow;
  logic [7:0] b_out_idx;

  logic       sel;
  logic       m_in_ready, m_out_valid, m_out_last, m_overflow;
  logic [7:0] m_out_idx;

  int checks   = 0;
  int failures = 0;

  logic [8:0] q[$];

  typedef struct {
    int         grp;
    logic [7:0] ch;
    logic [7:0] idx;
    logic       last;
  } vec_t;

  vec_t vt [19];

  always #5 clk = ~clk;

  mtf_encoder u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_char(in_char),
    .in_ready(a_in_ready), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_idx(a_out_idx), .out_last(a_out_last), .overflow(a_overflow)
  );

  mtf_encoder #(.STRING_LEN(4), .FIFO_DEPTH(4)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_char(in_char),
    .in_ready(b_in_ready), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_idx(b_out_idx), .out_last(b_out_last), .overflow(b_overflow)
  );

  always_comb begin
    m_in_ready  = sel ? b_in_ready  : a_in_ready;
    m_out_valid = sel ? b_out_valid : a_out_valid;
    m_out_idx   = sel ? b_out_idx   : a_out_idx;
    m_out_last  = sel ? b_out_last  : a_out_last;
    m_overflow  = sel ? b_overflow  : a_overflow;
  end

  // Record every handshake on the selected instance.
  always @(negedge clk) begin
    if (!rst && m_out_valid && out_ready) q.push_back({m_out_last, m_out_idx});
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset(input logic s);
    sel       = s;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_char   = 8'h00;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
  endtask

  task automatic feed(input logic [7:0] c);
    in_valid = 1'b1;
    in_char  = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_q(input int n);
    for (int i = 0; i < 60 && q.size() < n; i++) @(posedge clk);
    #1;
    if (q.size() < n) begin
      checks++;
      failures++;
      $display("FAIL wait_q: got %0d outputs expected %0d", q.size(), n);
    end
  endtask

  task automatic cmp_q(input string name, input int k, input int idx, input int last);
    if (k < q.size()) begin
      chk({name, "_idx"},  int'(q[k][7:0]), idx);
      chk({name, "_last"}, int'(q[k][8]),   last);
    end
  endtask

  task automatic run_group(input int g);
    int n;
    int k;
    n = 0;
    for (int i = 0; i < 19; i++) begin
      if (vt[i].grp == g) begin
        feed(vt[i].ch);
        n++;
      end
    end
    wait_q(n);
    repeat (3) @(posedge clk);
    #1;
    chk($sformatf("grp%0d_count", g), q.size(), n);
    k = 0;
    for (int i = 0; i < 19; i++) begin
      if (vt[i].grp == g) begin
        cmp_q($sformatf("grp%0d_v%0d", g, k), k, int'(vt[i].idx), int'(vt[i].last));
        k++;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vt = '{
      '{0, 8'h62, 8'd98,  1'b0}, '{0, 8'h61, 8'd98,  1'b0}, '{0, 8'h6E, 8'd110, 1'b0},
      '{0, 8'h61, 8'd1,   1'b0}, '{0, 8'h6E, 8'd1,   1'b0}, '{0, 8'h61, 8'd1,   1'b0},
      '{1, 8'h05, 8'd5,   1'b0}, '{1, 8'h05, 8'd0,   1'b0}, '{1, 8'h05, 8'd0,   1'b0},
      '{1, 8'h05, 8'd0,   1'b1}, '{1, 8'h05, 8'd5,   1'b0},
      '{2, 8'h41, 8'd65,  1'b0}, '{2, 8'h41, 8'd0,   1'b0}, '{2, 8'h00, 8'd1,   1'b0},
      '{2, 8'hFF, 8'd255, 1'b0},
      '{3, 8'h05, 8'd5,   1'b0}, '{3, 8'h05, 8'd0,   1'b0}, '{3, 8'h05, 8'd0,   1'b0},
      '{3, 8'h05, 8'd0,   1'b1}
    };

    // Reset state on both instances
    do_reset(1'b0);
    chk("rst_a_out_valid", a_out_valid, 0);
    chk("rst_a_out_idx",   a_out_idx,   0);
    chk("rst_a_out_last",  a_out_last,  0);
    chk("rst_a_in_ready",  a_in_ready,  1);
    chk("rst_a_overflow",  a_overflow,  0);
    chk("rst_b_in_ready",  b_in_ready,  1);
    chk("rst_b_out_valid", b_out_valid, 0);

    // First-accept latency
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_char   = 8'h62;
    chk("lat_before", a_out_valid, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("lat_after_valid", a_out_valid, 1);
    chk("lat_after_idx",   a_out_idx,   98);

    // Table-driven streams
    for (int g = 0; g < 3; g++) begin
      do_reset(g == 1);
      out_ready = 1'b1;
      run_group(g);
    end

    // Fill the 4-deep FIFO, overflow on the 5th, then drain
    do_reset(1'b1);
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_char  = 8'h10 + 8'(i);
      @(posedge clk);
      #1;
      if (i == 3) begin
        chk("full_in_ready", b_in_ready, 0);
        chk("full_no_ovf",   b_overflow, 0);
      end
      if (i == 4) chk("ovf_set", b_overflow, 1);
    end
    in_valid = 1'b0;
    chk("full_out_valid", b_out_valid, 1);
    out_ready = 1'b1;
    wait_q(4);
    repeat (3) @(posedge clk);
    #1;
    chk("drain_count", q.size(), 4);
    cmp_q("drain0", 0, 16, 0);
    cmp_q("drain1", 1, 17, 0);
    cmp_q("drain2", 2, 18, 0);
    cmp_q("drain3", 3, 19, 1);
    chk("drain_in_ready",  b_in_ready,  1);
    chk("drain_out_valid", b_out_valid, 0);
    chk("drain_hold_idx",  b_out_idx,   19);
    chk("ovf_sticky",      b_overflow,  1);

    // Full FIFO with simultaneous pop and presented character
    do_reset(1'b1);
    for (int i = 0; i < 4; i++) feed(8'h20 + 8'(i));
    chk("pp_full", b_in_ready, 0);
    in_valid  = 1'b1;
    in_char   = 8'h20;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("pp_ready_after_pop", b_in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("pp_ready_after_pushpop", b_in_ready, 1);
    wait_q(5);
    repeat (3) @(posedge clk);
    #1;
    chk("pp_count", q.size(), 5);
    cmp_q("pp0", 0, 32, 0);
    cmp_q("pp1", 1, 33, 0);
    cmp_q("pp2", 2, 34, 0);
    cmp_q("pp3", 3, 35, 1);
    cmp_q("pp4", 4, 32, 0);

    // Reset mid-block discards FIFO, count and table
    do_reset(1'b1);
    feed(8'h07);
    feed(8'h09);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    chk("mid_out_valid", b_out_valid, 0);
    chk("mid_overflow",  b_overflow,  0);
    chk("mid_out_idx",   b_out_idx,   0);
    out_ready = 1'b1;
    run_group(3);
    chk("mid_overflow_end", b_overflow, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
